// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard and forwarding controller for the 5-stage RV32I pipeline.
//   Keeps a registered copy of the EX/MEM/WB register-usage metadata and
//   derives operand forwarding selects, pc+4 link-forward selects, the
//   load-use stall and the multi-cycle MDU blocking stall from it.
//
// Ports
//   clk_i, rst_i           clock (rising edge), synchronous active-high reset
//   id_valid_i             ID holds a real instruction
//   id_rs_i                ID source regs, port k at [k*REG_AW +: REG_AW]
//   id_rs_used_i           per-port "source actually read"
//   id_rd_i, id_we_i       ID destination and its write enable
//   id_is_load_i           ID class flag: load
//   id_is_link_i           ID class flag: jal/jalr (result is pc+4)
//   id_is_mdu_i            ID class flag: multi-cycle MDU op
//   flush_i                taken branch/jump resolved in EX, kill ID
//   fwd_sel_o              per port 2 bits: 00 regfile, 01 MEM, 10 WB
//   pc4_sel_o              per port: forwarded value is the producer's pc+4
//   stall_o                hold PC and IF/ID
//   ex/mem/wb_valid_o      stage occupancy
//   mdu_busy_o             MDU countdown non-zero
module hazard_scoreboard #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MDU_LAT = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      id_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
    input  logic [NUM_SRC-1:0]        id_rs_used_i,
    input  logic [REG_AW-1:0]         id_rd_i,
    input  logic                      id_we_i,
    input  logic                      id_is_load_i,
    input  logic                      id_is_link_i,
    input  logic                      id_is_mdu_i,
    input  logic                      flush_i,
    output logic [2*NUM_SRC-1:0]      fwd_sel_o,
    output logic [NUM_SRC-1:0]        pc4_sel_o,
    output logic                      stall_o,
    output logic                      ex_valid_o,
    output logic                      mem_valid_o,
    output logic                      wb_valid_o,
    output logic                      mdu_busy_o
);

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_e;

    localparam logic [3:0] MDU_CNT_INIT = 4'(MDU_LAT - 1);

    // EX stage metadata
    logic                      ex_valid;
    logic [REG_AW-1:0]         ex_rd;
    logic                      ex_we;
    logic                      ex_link;
    logic                      ex_load;
    logic [NUM_SRC*REG_AW-1:0] ex_rs;
    logic [NUM_SRC-1:0]        ex_rs_used;

    // MEM stage metadata
    logic                      mem_valid;
    logic [REG_AW-1:0]         mem_rd;
    logic                      mem_we;
    logic                      mem_link;

    // WB stage metadata
    logic                      wb_valid;
    logic [REG_AW-1:0]         wb_rd;
    logic                      wb_we;
    logic                      wb_link;

    logic [3:0]                mdu_cnt;
    logic                      mdu_busy;
    logic                      ldu_hit;
    logic                      ldu;
    logic [REG_AW-1:0]         fwd_rs;

    assign mdu_busy = (mdu_cnt != '0);

    // Load-use: a load in EX whose rd is read by the instruction in ID.
    always_comb begin
        ldu_hit = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (id_rs_used_i[k] && (id_rs_i[k*REG_AW +: REG_AW] == ex_rd))
                ldu_hit = 1'b1;
        end
        ldu = ex_valid && ex_load && ex_we && (ex_rd != '0) && id_valid_i && ldu_hit;
    end

    assign stall_o = ldu | mdu_busy;

    // Forwarding selects from registered state only; MEM is younger and wins.
    always_comb begin
        fwd_sel_o = '0;
        pc4_sel_o = '0;
        fwd_rs    = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            fwd_rs = ex_rs[k*REG_AW +: REG_AW];
            if (ex_valid && ex_rs_used[k] && (fwd_rs != '0)) begin
                if (mem_valid && mem_we && (mem_rd == fwd_rs)) begin
                    fwd_sel_o[2*k +: 2] = FWD_MEM;
                    pc4_sel_o[k]        = mem_link;
                end else if (wb_valid && wb_we && (wb_rd == fwd_rs)) begin
                    fwd_sel_o[2*k +: 2] = FWD_WB;
                    pc4_sel_o[k]        = wb_link;
                end
            end
        end
    end

    // WB always takes MEM. MDU countdown holds EX and bubbles MEM; load-use
    // bubbles EX and lets the load move on; otherwise the pipe advances.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid   <= 1'b0;
            ex_rd      <= '0;
            ex_we      <= 1'b0;
            ex_link    <= 1'b0;
            ex_load    <= 1'b0;
            ex_rs      <= '0;
            ex_rs_used <= '0;
            mem_valid  <= 1'b0;
            mem_rd     <= '0;
            mem_we     <= 1'b0;
            mem_link   <= 1'b0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_we      <= 1'b0;
            wb_link    <= 1'b0;
            mdu_cnt    <= '0;
        end else begin
            wb_valid <= mem_valid;
            wb_rd    <= mem_rd;
            wb_we    <= mem_we;
            wb_link  <= mem_link;
            if (mdu_busy) begin
                mem_valid <= 1'b0;
                mdu_cnt   <= mdu_cnt - 4'd1;
            end else begin
                mem_valid <= ex_valid;
                mem_rd    <= ex_rd;
                mem_we    <= ex_we;
                mem_link  <= ex_link;
                if (ldu) begin
                    ex_valid <= 1'b0;
                end else begin
                    ex_valid   <= id_valid_i & ~flush_i;
                    ex_rd      <= id_rd_i;
                    ex_we      <= id_we_i;
                    ex_link    <= id_is_link_i;
                    ex_load    <= id_is_load_i;
                    ex_rs      <= id_rs_i;
                    ex_rs_used <= id_rs_used_i;
                    mdu_cnt    <= (id_valid_i && !flush_i && id_is_mdu_i) ? MDU_CNT_INIT : '0;
                end
            end
        end
    end

    assign ex_valid_o  = ex_valid;
    assign mem_valid_o = mem_valid;
    assign wb_valid_o  = wb_valid;
    assign mdu_busy_o  = mdu_busy;

    // A flush during a stall is dropped by the pipe; make that visible.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(flush_i && stall_o))
                else $warning("hazard_scoreboard: flush_i dropped because stall_o was high");
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int unsigned NS  = 2;
    localparam int unsigned AW  = 5;
    localparam int unsigned LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_i;
    logic              id_valid_i;
    logic [NS*AW-1:0]  id_rs_i;
    logic [NS-1:0]     id_rs_used_i;
    logic [AW-1:0]     id_rd_i;
    logic              id_we_i;
    logic              id_is_load_i;
    logic              id_is_link_i;
    logic              id_is_mdu_i;
    logic              flush_i;
    logic [2*NS-1:0]   fwd_sel_o;
    logic [NS-1:0]     pc4_sel_o;
    logic              stall_o;
    logic              ex_valid_o;
    logic              mem_valid_o;
    logic              wb_valid_o;
    logic              mdu_busy_o;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard #(
        .NUM_SRC (NS),
        .REG_AW  (AW),
        .MDU_LAT (LAT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .id_valid_i   (id_valid_i),
        .id_rs_i      (id_rs_i),
        .id_rs_used_i (id_rs_used_i),
        .id_rd_i      (id_rd_i),
        .id_we_i      (id_we_i),
        .id_is_load_i (id_is_load_i),
        .id_is_link_i (id_is_link_i),
        .id_is_mdu_i  (id_is_mdu_i),
        .flush_i      (flush_i),
        .fwd_sel_o    (fwd_sel_o),
        .pc4_sel_o    (pc4_sel_o),
        .stall_o      (stall_o),
        .ex_valid_o   (ex_valid_o),
        .mem_valid_o  (mem_valid_o),
        .wb_valid_o   (wb_valid_o),
        .mdu_busy_o   (mdu_busy_o)
    );

    // Reference model: one instruction record per stage plus the number of
    // EX cycles the current MDU op still needs.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
        logic       link;
        logic       load;
        logic       mdu;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] used;
    } ins_t;

    ins_t m_ex = '0, m_mem = '0, m_wb = '0;
    int   m_left = 0;
    logic m_stall, m_mdu_stall, m_ldu;
    logic [3:0] m_fwd;
    logic [1:0] m_pc4;

    function automatic logic writes(ins_t s, logic [4:0] r);
        return s.v && s.we && (s.rd == r);
    endfunction

    // {pc4, sel} for one EX operand
    function automatic logic [2:0] pick(logic [4:0] r, logic u);
        if (!m_ex.v || !u || r == 5'd0) return 3'b000;
        if (writes(m_mem, r)) return {m_mem.link, 2'b01};
        if (writes(m_wb, r))  return {m_wb.link, 2'b10};
        return 3'b000;
    endfunction

    function void model_eval();
        logic [2:0] a;
        logic [2:0] b;
        m_mdu_stall = (m_left > 1);
        m_ldu = m_ex.v && m_ex.load && m_ex.we && (m_ex.rd != 5'd0) && id_valid_i &&
                ((id_rs_used_i[0] && id_rs_i[4:0] == m_ex.rd) ||
                 (id_rs_used_i[1] && id_rs_i[9:5] == m_ex.rd));
        m_stall = m_mdu_stall || m_ldu;
        a = pick(m_ex.rs0, m_ex.used[0]);
        b = pick(m_ex.rs1, m_ex.used[1]);
        m_fwd = {b[1:0], a[1:0]};
        m_pc4 = {b[2], a[2]};
    endfunction

    function void model_advance();
        ins_t id;
        id = '0;
        if (id_valid_i && !flush_i) begin
            id.v    = 1'b1;
            id.rd   = id_rd_i;
            id.we   = id_we_i;
            id.link = id_is_link_i;
            id.load = id_is_load_i;
            id.mdu  = id_is_mdu_i;
            id.rs0  = id_rs_i[4:0];
            id.rs1  = id_rs_i[9:5];
            id.used = id_rs_used_i;
        end
        if (rst_i) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_left = 0;
        end else if (m_mdu_stall) begin
            m_wb = m_mem; m_mem = '0; m_left = m_left - 1;
        end else if (m_ldu) begin
            m_wb = m_mem; m_mem = m_ex; m_ex = '0; m_left = 0;
        end else begin
            m_wb = m_mem; m_mem = m_ex; m_ex = id;
            m_left = (id.v && id.mdu) ? int'(LAT) : 0;
        end
    endfunction

    // One clock: evaluate model on pre-edge values, clock, update, park at negedge.
    task automatic tick();
        model_eval();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic issue(int rd, int a, int b, logic [1:0] used,
                         logic we, logic load, logic link, logic mdu);
        id_valid_i   = 1'b1;
        id_rd_i      = 5'(rd);
        id_rs_i      = {5'(b), 5'(a)};
        id_rs_used_i = used;
        id_we_i      = we;
        id_is_load_i = load;
        id_is_link_i = link;
        id_is_mdu_i  = mdu;
    endtask

    task automatic idle();
        id_valid_i   = 1'b0;
        id_rd_i      = '0;
        id_rs_i      = '0;
        id_rs_used_i = '0;
        id_we_i      = 1'b0;
        id_is_load_i = 1'b0;
        id_is_link_i = 1'b0;
        id_is_mdu_i  = 1'b0;
        flush_i      = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (5) tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle();
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        total++;
        if ({stall_o, mdu_busy_o, ex_valid_o, mem_valid_o, wb_valid_o, pc4_sel_o, fwd_sel_o} !== 11'd0) begin
            bad++;
            $display("FAIL reset_state got=%b exp=%b",
                     {stall_o, mdu_busy_o, ex_valid_o, mem_valid_o, wb_valid_o, pc4_sel_o, fwd_sel_o}, 11'd0);
        end
    endtask

    task automatic test_chain();
        logic any_stall;
        any_stall = 1'b0;
        drain();
        issue(5, 3, 2, 2'b11, 1, 0, 0, 0);      // add x5,x3,x2
        #1 any_stall |= stall_o;
        tick();
        issue(6, 5, 1, 2'b11, 1, 0, 0, 0);      // xor x6,x5,x1
        #1 any_stall |= stall_o;
        tick();
        total++;
        if (fwd_sel_o !== 4'b0001) begin
            bad++; $display("FAIL chain_xor fwd got=%b exp=%b", fwd_sel_o, 4'b0001);
        end
        issue(9, 3, 5, 2'b11, 1, 0, 0, 0);      // sub x9,x3,x5
        #1 any_stall |= stall_o;
        tick();
        total++;
        if (fwd_sel_o !== 4'b1000) begin
            bad++; $display("FAIL chain_sub fwd got=%b exp=%b", fwd_sel_o, 4'b1000);
        end
        issue(2, 7, 5, 2'b11, 1, 0, 0, 0);      // or x2,x7,x5
        #1 any_stall |= stall_o;
        tick();
        total++;
        if (fwd_sel_o !== 4'b0000) begin
            bad++; $display("FAIL chain_or fwd got=%b exp=%b", fwd_sel_o, 4'b0000);
        end
        total++;
        if (any_stall !== 1'b0) begin
            bad++; $display("FAIL chain_stall got=%b exp=0", any_stall);
        end
    endtask

    task automatic test_mem_wb_priority();
        drain();
        issue(1, 0, 2, 2'b11, 1, 0, 0, 0);      // add x1,x0,x2
        tick();
        issue(2, 0, 3, 2'b11, 1, 0, 0, 0);      // add x2,x0,x3
        tick();
        issue(3, 1, 2, 2'b11, 1, 0, 0, 0);      // sub x3,x1,x2
        tick();
        total++;
        if (fwd_sel_o !== 4'b0110) begin
            bad++; $display("FAIL prio_sub fwd got=%b exp=%b", fwd_sel_o, 4'b0110);
        end
        issue(1, 0, 2, 2'b11, 1, 0, 0, 0);      // add x1,x0,x2
        tick();
        issue(1, 0, 3, 2'b11, 1, 0, 0, 0);      // add x1,x0,x3
        tick();
        issue(4, 1, 0, 2'b11, 1, 0, 0, 0);      // add x4,x1,x0
        tick();
        total++;
        if (fwd_sel_o !== 4'b0001) begin
            bad++; $display("FAIL prio_mem_over_wb fwd got=%b exp=%b", fwd_sel_o, 4'b0001);
        end
    endtask

    task automatic test_link();
        drain();
        issue(1, 0, 0, 2'b00, 1, 0, 1, 0);      // jal x1,4
        tick();
        issue(2, 1, 0, 2'b11, 1, 0, 0, 0);      // add x2,x1,x0
        tick();
        total++;
        if ({pc4_sel_o, fwd_sel_o} !== 6'b01_0001) begin
            bad++; $display("FAIL link_add_x2 pc4/fwd got=%b exp=%b", {pc4_sel_o, fwd_sel_o}, 6'b01_0001);
        end
        issue(3, 0, 1, 2'b11, 1, 0, 0, 0);      // add x3,x0,x1
        tick();
        total++;
        if ({pc4_sel_o, fwd_sel_o} !== 6'b10_1000) begin
            bad++; $display("FAIL link_add_x3 pc4/fwd got=%b exp=%b", {pc4_sel_o, fwd_sel_o}, 6'b10_1000);
        end
        issue(4, 0, 0, 2'b00, 1, 0, 1, 0);      // jal x4,4
        tick();
        issue(5, 0, 0, 2'b00, 1, 0, 1, 0);      // jal x5,8
        tick();
        issue(6, 4, 5, 2'b11, 1, 0, 0, 0);      // add x6,x4,x5
        tick();
        total++;
        if ({pc4_sel_o, fwd_sel_o} !== 6'b11_0110) begin
            bad++; $display("FAIL link_add_x6 pc4/fwd got=%b exp=%b", {pc4_sel_o, fwd_sel_o}, 6'b11_0110);
        end
    endtask

    task automatic test_load_use();
        drain();
        issue(5, 1, 0, 2'b01, 1, 1, 0, 0);      // lw x5,0(x1)
        tick();
        issue(6, 5, 5, 2'b11, 1, 0, 0, 0);      // add x6,x5,x5
        #1;
        total++;
        if (stall_o !== 1'b1) begin
            bad++; $display("FAIL ldu_stall_on got=%b exp=1", stall_o);
        end
        tick();
        #1;
        total++;
        if ({stall_o, ex_valid_o, mem_valid_o} !== 3'b001) begin
            bad++; $display("FAIL ldu_bubble stall/ex/mem got=%b exp=001", {stall_o, ex_valid_o, mem_valid_o});
        end
        tick();
        total++;
        if (fwd_sel_o !== 4'b1010) begin
            bad++; $display("FAIL ldu_consumer fwd got=%b exp=%b", fwd_sel_o, 4'b1010);
        end
        issue(0, 1, 0, 2'b01, 1, 1, 0, 0);      // lw x0,0(x1)
        tick();
        issue(6, 0, 0, 2'b11, 1, 0, 0, 0);      // add x6,x0,x0
        #1;
        total++;
        if (stall_o !== 1'b0) begin
            bad++; $display("FAIL ldu_x0_nostall got=%b exp=0", stall_o);
        end
        tick();
        total++;
        if ({ex_valid_o, fwd_sel_o} !== 5'b1_0000) begin
            bad++; $display("FAIL ldu_x0_fwd ex/fwd got=%b exp=%b", {ex_valid_o, fwd_sel_o}, 5'b1_0000);
        end
    endtask

    task automatic test_mdu();
        drain();
        issue(7, 1, 2, 2'b11, 1, 0, 0, 1);      // mul x7,x1,x2
        tick();
        issue(8, 7, 0, 2'b11, 1, 0, 0, 0);      // add x8,x7,x0
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({stall_o, mdu_busy_o} !== 2'b11) begin
                bad++; $display("FAIL mdu_stall_%0d stall/busy got=%b exp=11", i, {stall_o, mdu_busy_o});
            end
            tick();
            total++;
            if (mem_valid_o !== 1'b0) begin
                bad++; $display("FAIL mdu_mem_bubble_%0d got=%b exp=0", i, mem_valid_o);
            end
        end
        #1;
        total++;
        if ({stall_o, mdu_busy_o, ex_valid_o} !== 3'b001) begin
            bad++; $display("FAIL mdu_release stall/busy/ex got=%b exp=001", {stall_o, mdu_busy_o, ex_valid_o});
        end
        tick();
        total++;
        if (fwd_sel_o !== 4'b0001) begin
            bad++; $display("FAIL mdu_consumer fwd got=%b exp=%b", fwd_sel_o, 4'b0001);
        end
    endtask

    task automatic test_reset_mid_mdu();
        drain();
        issue(7, 1, 2, 2'b11, 1, 0, 0, 1);      // mul x7,x1,x2
        tick();
        issue(8, 7, 0, 2'b11, 1, 0, 0, 0);
        tick();
        #1;
        total++;
        if (stall_o !== 1'b1) begin
            bad++; $display("FAIL rstmdu_pre got=%b exp=1", stall_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        total++;
        if ({stall_o, mdu_busy_o, ex_valid_o, mem_valid_o, wb_valid_o, pc4_sel_o, fwd_sel_o} !== 11'd0) begin
            bad++;
            $display("FAIL rstmdu_clear got=%b exp=%b",
                     {stall_o, mdu_busy_o, ex_valid_o, mem_valid_o, wb_valid_o, pc4_sel_o, fwd_sel_o}, 11'd0);
        end
    endtask

    task automatic test_flush();
        drain();
        issue(5, 1, 0, 2'b01, 1, 1, 0, 0);      // lw x5,0(x1)
        tick();
        issue(6, 5, 5, 2'b11, 1, 0, 0, 0);      // add x6,x5,x5
        flush_i = 1'b1;                         // ignored: stall wins
        tick();
        flush_i = 1'b0;
        #1;
        total++;
        if (ex_valid_o !== 1'b0) begin
            bad++; $display("FAIL flush_ldu_bubble got=%b exp=0", ex_valid_o);
        end
        tick();
        total++;
        if ({ex_valid_o, fwd_sel_o} !== 5'b1_1010) begin
            bad++; $display("FAIL flush_ignored ex/fwd got=%b exp=%b", {ex_valid_o, fwd_sel_o}, 5'b1_1010);
        end
        issue(9, 1, 2, 2'b11, 1, 0, 0, 0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        total++;
        if (ex_valid_o !== 1'b0) begin
            bad++; $display("FAIL flush_alone got=%b exp=0", ex_valid_o);
        end
    endtask

    task automatic test_random();
        int cls;
        drain();
        for (int c = 0; c < 3000; c++) begin
            rst_i = ($urandom_range(0, 99) == 0);
            cls   = $urandom_range(0, 5);
            issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  2'($urandom_range(0, 3)),
                  (cls != 2), (cls == 3), (cls == 4), (cls == 5));
            id_valid_i = ($urandom_range(0, 3) != 0);
            flush_i    = ($urandom_range(0, 9) == 0);
            model_eval();
            if (m_stall) flush_i = 1'b0;
            #1;
            total++;
            if (stall_o !== m_stall) begin
                bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, stall_o, m_stall);
            end
            total++;
            if (fwd_sel_o !== m_fwd) begin
                bad++; $display("FAIL rnd_fwd cyc=%0d got=%b exp=%b", c, fwd_sel_o, m_fwd);
            end
            total++;
            if (pc4_sel_o !== m_pc4) begin
                bad++; $display("FAIL rnd_pc4 cyc=%0d got=%b exp=%b", c, pc4_sel_o, m_pc4);
            end
            total++;
            if ({ex_valid_o, mem_valid_o, wb_valid_o} !== {m_ex.v, m_mem.v, m_wb.v}) begin
                bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c,
                                {ex_valid_o, mem_valid_o, wb_valid_o}, {m_ex.v, m_mem.v, m_wb.v});
            end
            total++;
            if (mdu_busy_o !== m_mdu_stall) begin
                bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, mdu_busy_o, m_mdu_stall);
            end
            tick();
        end
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        @(negedge clk);
        test_reset();
        test_chain();
        test_mem_wb_priority();
        test_link();
        test_load_use();
        test_mdu();
        test_reset_mid_mdu();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the 5-stage RV32I pipeline. It owns a registered copy of the EX/MEM/WB register-usage metadata (valid, rd, write-enable, link, load, MDU). From that state it produces operand forwarding selects for NUM_SRC EX source ports, pc+4 link-forward selects, a load-use stall, and a blocking stall for a multi-cycle MDU of configurable latency. It sits beside the ID/EX boundary and drives the pipeline-register enables and bubble inserts.

## Interface
- NUM_SRC, 2: EX source operand ports (2 or 3).
- REG_AW, 5: register address width.
- MDU_LAT, 4: MDU op cycles in EX, 1..15; 1 means no MDU stall.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs_i  in  NUM_SRC*REG_AW  ID source regs, port k at [k*REG_AW +: REG_AW].
- id_rs_used_i  in  NUM_SRC  per-port "source actually read".
- id_rd_i  in  REG_AW  ID destination.
- id_we_i  in  1  ID writes rd.
- id_is_load_i, id_is_link_i, id_is_mdu_i  in  1 each  ID class flags (link = jal/jalr).
- flush_i  in  1  taken branch/jump resolved in EX; kill ID.
- fwd_sel_o  out  2*NUM_SRC  per port: 00 regfile, 01 MEM, 10 WB.
- pc4_sel_o  out  NUM_SRC  per port: the forwarded value is the producer's pc+4.
- stall_o  out  1  hold PC and IF/ID.
- ex_valid_o, mem_valid_o, wb_valid_o  out  1 each  stage occupancy.
- mdu_busy_o  out  1  MDU countdown non-zero.

## Operation
- State per stage S in {EX, MEM, WB}: valid, rd, we, link, load, mdu. EX also holds rs[NUM_SRC] and rs_used.
- Advance, when stall_o=0: EX <= ID fields, valid = id_valid_i & ~flush_i. MEM <= EX. WB <= MEM.
- Load-use stall, ldu: EX.valid & EX.load & EX.we & EX.rd!=0 & id_valid_i, with any port k where id_rs_used_i[k] & id_rs[k]==EX.rd. On ldu, EX <= bubble (valid=0), MEM <= EX, WB <= MEM; ID is held.
- MDU stall: on the edge an MDU op enters EX, cnt <= MDU_LAT-1. While cnt!=0: stall_o=1, EX holds, MEM <= bubble, WB <= MEM, cnt decrements. The op leaves EX on the edge after cnt reaches 0.
- stall_o = ldu | (cnt!=0).
- Forwarding for port k, requiring EX.rs_used[k] and EX.rs[k]!=0:
  - MEM match (MEM.valid & MEM.we & MEM.rd==rs) gives 01.
  - Else a WB match gives 10.
  - Else 00.
  - MEM beats WB.
  - pc4_sel_o[k] = link flag of the selected stage; 0 when sel is 00.
- While cnt!=0, the selects remain valid for the held EX op.
- x0 is never forwarded or stalled on.
- A flush_i asserted while stall_o=1 is ignored (stall wins). The block must not drop it silently: an assertion fires in simulation.

## Timing
- Reset: all valid bits 0, cnt 0, fwd_sel_o 0, pc4_sel_o 0, stall_o 0, mdu_busy_o 0, occupancy outputs 0.
- Reset mid-MDU or mid-ldu clears everything on that edge. stall_o is 0 in the next cycle.
- fwd_sel_o and pc4_sel_o are combinational from registered state only. They are valid the whole cycle the consumer is in EX.
- stall_o is combinational from registered state plus ID inputs, with no input-to-state loop.
- An instruction accepted at edge n is in EX during cycle n+1, MEM in n+2, and WB in n+3, absent stalls.
- Load-use costs exactly 1 stall cycle. The load is then in WB when the consumer reaches EX, so the consumer gets sel 10.
- MDU costs MDU_LAT-1 stall cycles.

## Test plan
- Chain: add x5,x3,x2 / xor x6,x5,x1 / sub x9,x3,x5 / or x2,x7,x5 -> xor: A=01, B=00. sub: A=00, B=10. or: B=00 (x5 already in regfile). stall_o=0 throughout.
- add x1,x0,x2 / add x2,x0,x3 / sub x3,x1,x2 -> sub: A=10, B=01. MEM-over-WB priority also checked with add x1 twice followed by a use of x1, which must give 01.
- jal x1,4 / add x2,x1,x0 / add x3,x0,x1 / jal x4,4 / jal x5,8 / add x6,x4,x5:
  - add x2: A=01, pc4A=1.
  - add x3: B=10, pc4B=1.
  - add x6: A=10, pc4A=1, B=01, pc4B=1.
- lw x5,0(x1) / add x6,x5,x5 -> stall_o=1 for exactly 1 cycle with EX bubble. Then add in EX: A=B=10. A lw to x0 followed by its use gives no stall.
- MDU_LAT=4: mul x7,x1,x2 / add x8,x7,x0 -> stall_o=1 for 3 cycles, mdu_busy_o=1 for the same 3 cycles, MEM bubbles. Then add in EX: A=01.
- rst_i asserted on the 2nd MDU stall cycle -> next cycle all outputs 0. flush_i during the load-use stall -> ignored and assertion fires. flush_i alone -> ex_valid_o=0 next cycle.
